nt_hormone_level: RTL and testbench

Parametrised hormone/neurotransmitter resource. It succeeds the fixed 7-bit cortisol resource and adds three things: autonomous decay toward a rest value, runtime load, and a hysteretic downscaled level output with a change strobe. It sits between an nt_*_regulator, which drives inc/dec/fast, and the emotion/behaviour logic, which consumes level. One instance is used per hormone channel.

---
 rtl/nt_pkg.sv | 26 ++
 rtl/nt_level_quantizer.sv | 49 ++++
 rtl/nt_hormone_level.sv | 99 +++++++++
 tb/tb_nt_hormone_level.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/nt_pkg.sv
// rtl/nt_pkg.sv - shared types and helpers for the nt_* hormone channels
// Level encodings and the saturating step used by every accumulator.
package nt_pkg;

  localparam logic [1:0] LVL_LOW  = 2'd0;
  localparam logic [1:0] LVL_MID  = 2'd1;
  localparam logic [1:0] LVL_HIGH = 2'd2;
  localparam logic [1:0] LVL_PEAK = 2'd3;

  // Saturating add/sub confined to [0, 2^width-1]; one guard bit catches overflow.
  function automatic logic [31:0] nt_sat_step(input logic [31:0] value,
                                              input logic [31:0] step,
                                              input logic        up,
                                              input int unsigned width);
    logic [32:0] max_v;
    logic [32:0] sum;
    max_v = (33'd1 << width) - 33'd1;
    sum   = {1'b0, value} + {1'b0, step};
    if (up) begin
      nt_sat_step = (sum > max_v) ? max_v[31:0] : sum[31:0];
    end else begin
      nt_sat_step = (step > value) ? 32'd0 : (value - step);
    end
  endfunction

endpackage

// File: rtl/nt_level_quantizer.sv
// rtl/nt_level_quantizer.sv - hysteretic downscaled level with change strobe
// Level follows upward at once; falls only once value drops HYST below the bucket floor.
module nt_level_quantizer
  import nt_pkg::*;
#(
  parameter int N           = 7,
  parameter int LEVEL_BITS  = 2,
  parameter int HYST        = 4,
  parameter int DEFAULT_VAL = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          value,
  output logic [LEVEL_BITS-1:0] level,
  output logic                  level_changed
);

  localparam logic [N-1:0] DEF_V = N'(DEFAULT_VAL);

  logic [LEVEL_BITS-1:0] level_q, level_d, raw;
  logic                  changed_q;
  logic [N:0]            floor_ext, value_hyst;

  always_comb begin
    raw        = value[N-1 -: LEVEL_BITS];
    floor_ext  = {1'b0, level_q, {(N-LEVEL_BITS){1'b0}}};
    value_hyst = {1'b0, value} + (N+1)'(HYST);
    level_d    = level_q;
    if (raw > level_q) begin
      level_d = raw;
    end else if (raw < level_q && value_hyst < floor_ext) begin
      level_d = raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= DEF_V[N-1 -: LEVEL_BITS];
      changed_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      changed_q <= (level_d != level_q);
    end
  end

  assign level         = level_q;
  assign level_changed = changed_q;

endmodule

// File: rtl/nt_hormone_level.sv
// rtl/nt_hormone_level.sv - saturating hormone accumulator with decay and runtime load
// Priority per edge: rst > setval > load > inc/dec > decay.
module nt_hormone_level
  import nt_pkg::*;
#(
  parameter int N            = 7,
  parameter int LEVEL_BITS   = 2,
  parameter int SET_VAL      = 64,
  parameter int DEFAULT_VAL  = 0,
  parameter int FAST_STEP    = 2,
  parameter int DECAY_PERIOD = 16,
  parameter int DECAY_TARGET = 0,
  parameter int HYST         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  fast,
  input  logic                  setval,
  input  logic                  load,
  input  logic [N-1:0]          load_value,
  input  logic                  decay_en,
  output logic [N-1:0]          value,
  output logic [LEVEL_BITS-1:0] level,
  output logic                  level_changed,
  output logic                  at_max,
  output logic                  at_min
);

  localparam int           CW     = (DECAY_PERIOD == 0) ? 1 : $clog2(DECAY_PERIOD + 1);
  localparam logic [N-1:0] TARGET = N'(DECAY_TARGET);

  logic [N-1:0]  value_q, value_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          decay_step;
  logic [31:0]   step;

  // Any request, or decay disabled, restarts the idle window.
  always_comb begin
    cnt_d      = '0;
    decay_step = 1'b0;
    if (decay_en && !(inc || dec || setval || load) && DECAY_PERIOD != 0) begin
      if (cnt_q == CW'(DECAY_PERIOD - 1)) begin
        decay_step = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    step    = fast ? 32'(FAST_STEP) : 32'd1;
    value_d = value_q;
    if (setval) begin
      value_d = N'(SET_VAL);
    end else if (load) begin
      value_d = load_value;
    end else if (inc && !dec) begin
      value_d = N'(nt_sat_step(32'(value_q), step, 1'b1, N));
    end else if (dec && !inc) begin
      value_d = N'(nt_sat_step(32'(value_q), step, 1'b0, N));
    end else if (decay_step) begin
      if (value_q < TARGET) begin
        value_d = value_q + N'(1);
      end else if (value_q > TARGET) begin
        value_d = value_q - N'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= N'(DEFAULT_VAL);
      cnt_q   <= '0;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
  end

  nt_level_quantizer #(
    .N          (N),
    .LEVEL_BITS (LEVEL_BITS),
    .HYST       (HYST),
    .DEFAULT_VAL(DEFAULT_VAL)
  ) u_quant (
    .clk          (clk),
    .rst          (rst),
    .value        (value_q),
    .level        (level),
    .level_changed(level_changed)
  );

  assign value  = value_q;
  assign at_max = (value_q == {N{1'b1}});
  assign at_min = (value_q == '0);

endmodule

// File: tb/tb_nt_hormone_level.sv
// tb/tb_nt_hormone_level.sv - directed bench for nt_hormone_level
// A second instance with DECAY_TARGET=20 shares the stimulus.
module tb_nt_hormone_level;
  import nt_pkg::*;

  logic       clk = 1'b0;
  logic       rst, inc, dec, fast, setval, load, decay_en;
  logic [6:0] load_value;
  logic [6:0] value, value2;
  logic [1:0] level, level2;
  logic       lc, lc2, at_max, at_max2, at_min, at_min2;

  int n_cmp = 0;
  int n_err = 0;

  nt_hormone_level u_dut (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .fast(fast), .setval(setval),
    .load(load), .load_value(load_value), .decay_en(decay_en), .value(value),
    .level(level), .level_changed(lc), .at_max(at_max), .at_min(at_min)
  );

  nt_hormone_level #(.DECAY_TARGET(20)) u_dut_t (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .fast(fast), .setval(setval),
    .load(load), .load_value(load_value), .decay_en(decay_en), .value(value2),
    .level(level2), .level_changed(lc2), .at_max(at_max2), .at_min(at_min2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    inc = 0; dec = 0; fast = 0; setval = 0; load = 0; decay_en = 0; load_value = '0;
  endtask

  task automatic test_reset();
    clear(); rst = 1; tick(); rst = 0;
    n_cmp++; if (value !== 7'd0) begin n_err++; $display("FAIL reset_value: got %0d expected 0", value); end
    n_cmp++; if (level !== LVL_LOW || lc !== 1'b0) begin n_err++; $display("FAIL reset_level: got level %0d strobe %0d expected 0 0", level, lc); end
    n_cmp++; if (at_min !== 1'b1 || at_max !== 1'b0) begin n_err++; $display("FAIL reset_flags: got min %0d max %0d expected 1 0", at_min, at_max); end
  endtask

  task automatic test_inc_ramp();
    inc = 1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      n_cmp++;
      if (value !== 7'(i) || at_min !== 1'b0 || level !== LVL_LOW || lc !== 1'b0) begin
        n_err++; $display("FAIL ramp_%0d: got value %0d min %0d level %0d strobe %0d expected %0d 0 0 0", i, value, at_min, level, lc, i);
      end
    end
    inc = 0; tick();
    n_cmp++; if (level !== LVL_MID || lc !== 1'b1 || value !== 7'd32) begin n_err++; $display("FAIL ramp_level_up: got level %0d strobe %0d value %0d expected 1 1 32", level, lc, value); end
    tick();
    n_cmp++; if (level !== LVL_MID || lc !== 1'b0) begin n_err++; $display("FAIL ramp_strobe_once: got level %0d strobe %0d expected 1 0", level, lc); end
  endtask

  task automatic test_saturation();
    int exp_v;
    setval = 1; tick(); setval = 0;
    n_cmp++; if (value !== 7'd64) begin n_err++; $display("FAIL setval: got %0d expected 64", value); end
    exp_v = 64; inc = 1; fast = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      exp_v = (exp_v + 2 > 127) ? 127 : exp_v + 2;
      n_cmp++; if (value !== 7'(exp_v)) begin n_err++; $display("FAIL sat_up_%0d: got %0d expected %0d", i, value, exp_v); end
    end
    n_cmp++; if (at_max !== 1'b1 || level !== LVL_PEAK) begin n_err++; $display("FAIL sat_top: got max %0d level %0d expected 1 3", at_max, level); end
    inc = 0; load = 1; load_value = 7'd1; tick(); load = 0; dec = 1;
    tick();
    n_cmp++; if (value !== 7'd0 || at_min !== 1'b1) begin n_err++; $display("FAIL sat_down: got %0d min %0d expected 0 1", value, at_min); end
    tick();
    n_cmp++; if (value !== 7'd0) begin n_err++; $display("FAIL sat_down_hold: got %0d expected 0", value); end
    clear();
  endtask

  task automatic test_hysteresis();
    load = 1; load_value = 7'd64; tick(); load = 0; tick();
    n_cmp++; if (level !== LVL_HIGH) begin n_err++; $display("FAIL hyst_start: got level %0d expected 2", level); end
    dec = 1; tick(); dec = 0; tick();
    n_cmp++; if (value !== 7'd63 || level !== LVL_HIGH) begin n_err++; $display("FAIL hyst_63: got value %0d level %0d expected 63 2", value, level); end
    dec = 1; repeat (3) tick(); dec = 0; tick();
    n_cmp++; if (value !== 7'd60 || level !== LVL_HIGH || lc !== 1'b0) begin n_err++; $display("FAIL hyst_60: got value %0d level %0d strobe %0d expected 60 2 0", value, level, lc); end
    dec = 1; tick(); dec = 0;
    n_cmp++; if (value !== 7'd59 || level !== LVL_HIGH) begin n_err++; $display("FAIL hyst_59_lag: got value %0d level %0d expected 59 2", value, level); end
    tick();
    n_cmp++; if (level !== LVL_MID || lc !== 1'b1) begin n_err++; $display("FAIL hyst_drop: got level %0d strobe %0d expected 1 1", level, lc); end
    inc = 1; repeat (5) tick(); inc = 0;
    n_cmp++; if (value !== 7'd64 || level !== LVL_MID) begin n_err++; $display("FAIL hyst_rise_lag: got value %0d level %0d expected 64 1", value, level); end
    tick();
    n_cmp++; if (level !== LVL_HIGH || lc !== 1'b1) begin n_err++; $display("FAIL hyst_rise: got level %0d strobe %0d expected 2 1", level, lc); end
  endtask

  task automatic test_decay();
    int e1, e2;
    load = 1; load_value = 7'd10; tick(); load = 0; decay_en = 1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      e1 = (i < 16) ? 10 : (i < 32) ? 9 : 8;
      e2 = (i < 16) ? 10 : (i < 32) ? 11 : 12;
      n_cmp++; if (value !== 7'(e1) || value2 !== 7'(e2)) begin n_err++; $display("FAIL decay_%0d: got %0d/%0d expected %0d/%0d", i, value, value2, e1, e2); end
    end
    load = 1; tick(); load = 0;
    repeat (8) tick();
    inc = 1; tick(); inc = 0;
    n_cmp++; if (value !== 7'd11 || value2 !== 7'd11) begin n_err++; $display("FAIL decay_inc: got %0d/%0d expected 11/11", value, value2); end
    for (int i = 1; i <= 16; i++) begin
      tick();
      e1 = (i < 16) ? 11 : 10;
      e2 = (i < 16) ? 11 : 12;
      n_cmp++; if (value !== 7'(e1) || value2 !== 7'(e2)) begin n_err++; $display("FAIL decay_restart_%0d: got %0d/%0d expected %0d/%0d", i, value, value2, e1, e2); end
    end
    clear();
  endtask

  task automatic test_simultaneous();
    decay_en = 1; load = 1; load_value = 7'd10; tick(); load = 0;
    repeat (10) tick();
    inc = 1; dec = 1; tick(); inc = 0; dec = 0;
    n_cmp++; if (value !== 7'd10) begin n_err++; $display("FAIL incdec_hold: got %0d expected 10", value); end
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_cmp++; if (value !== ((i < 16) ? 7'd10 : 7'd9)) begin n_err++; $display("FAIL incdec_cnt_%0d: got %0d expected %0d", i, value, (i < 16) ? 10 : 9); end
    end
    setval = 1; load = 1; load_value = 7'd30; inc = 1; tick(); setval = 0; inc = 0;
    n_cmp++; if (value !== 7'd64) begin n_err++; $display("FAIL setval_wins: got %0d expected 64", value); end
    load_value = 7'd5; dec = 1; tick();
    n_cmp++; if (value !== 7'd5) begin n_err++; $display("FAIL load_wins: got %0d expected 5", value); end
    clear();
  endtask

  task automatic test_reset_mid();
    load = 1; load_value = 7'd88; tick(); load = 0;
    inc = 1; fast = 1; tick(); inc = 0; fast = 0; decay_en = 1;
    repeat (10) tick();
    n_cmp++; if (value !== 7'd90 || level !== LVL_HIGH) begin n_err++; $display("FAIL pre_reset: got value %0d level %0d expected 90 2", value, level); end
    rst = 1; inc = 1; fast = 1; tick(); rst = 0; inc = 0; fast = 0;
    n_cmp++; if (value !== 7'd0 || level !== LVL_LOW || lc !== 1'b0 || value2 !== 7'd0) begin n_err++; $display("FAIL mid_reset: got value %0d level %0d strobe %0d value2 %0d expected 0 0 0 0", value, level, lc, value2); end
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_cmp++; if (value2 !== ((i < 16) ? 7'd0 : 7'd1) || lc !== 1'b0) begin n_err++; $display("FAIL post_reset_decay_%0d: got value2 %0d strobe %0d expected %0d 0", i, value2, lc, (i < 16) ? 0 : 1); end
    end
    decay_en = 0; inc = 1; fast = 1; tick();
    n_cmp++; if (value !== 7'd2 || lc !== 1'b0) begin n_err++; $display("FAIL resume: got value %0d strobe %0d expected 2 0", value, lc); end
    tick();
    n_cmp++; if (value !== 7'd4) begin n_err++; $display("FAIL resume2: got %0d expected 4", value); end
    clear();
  endtask

  initial begin
    rst = 1; clear();
    test_reset();
    test_inc_ramp();
    test_saturation();
    test_hysteresis();
    test_decay();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
